// File: rtl/alarm_trigger.sv
// Alarm time-compare and ring control (idle / ringing / snoozed) feeding led_alarm.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_trigger #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic [4:0] alm_hours,
  input  logic [5:0] alm_minutes,
  input  logic       alarm_en,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       alarm,
  output logic       snoozed,
  output logic [1:0] snooze_count
);

  localparam int RING_W = $clog2(RING_SECONDS + 1);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECONDS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZED = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [RING_W-1:0] ring_cnt_reg, ring_cnt_next;
  logic              block_reg, block_next;
  logic              alarm_reg, snoozed_reg;
  logic              match;

  assign match = tick_1hz && alarm_en && (cur_hours == alm_hours) &&
                 (cur_minutes == alm_minutes) && (cur_seconds == 6'd0);

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_SECONDS + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_SECONDS);
  localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZES);

  logic [SNZ_W-1:0] snz_cnt_reg, snz_cnt_next;
  logic [1:0]       scount_reg, scount_next;
`endif

  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
    block_next    = block_reg;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_next  = snz_cnt_reg;
    scount_next   = scount_reg;
`endif
    // Leaving the alarm minute re-enables matching after a dismiss.
    if (cur_minutes != alm_minutes)
      block_next = 1'b0;

    if (!alarm_en) begin
      state_next    = IDLE;
      ring_cnt_next = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_next  = '0;
      scount_next   = '0;
`endif
    end else if (dismiss && (state_reg != IDLE)) begin
      state_next    = IDLE;
      ring_cnt_next = '0;
      block_next    = 1'b1;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_next  = '0;
      scount_next   = '0;
    end else if (snooze && (state_reg == RINGING) && (scount_reg < SNOOZE_MAX)) begin
      state_next    = SNOOZED;
      ring_cnt_next = '0;
      snz_cnt_next  = SNZ_LOAD;
      scount_next   = scount_reg + 2'd1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (match && !block_reg) begin
            state_next    = RINGING;
            ring_cnt_next = RING_LOAD;
          end
        end
        RINGING: begin
          if (tick_1hz) begin
            // This tick takes the count to zero: ring ends now.
            if (ring_cnt_reg <= RING_W'(1)) begin
              state_next    = IDLE;
              ring_cnt_next = '0;
`ifdef ALARM_SNOOZE_EN
              scount_next   = '0;
`endif
            end else begin
              ring_cnt_next = ring_cnt_reg - RING_W'(1);
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZED: begin
          if (tick_1hz) begin
            if (snz_cnt_reg <= SNZ_W'(1)) begin
              state_next    = RINGING;
              snz_cnt_next  = '0;
              ring_cnt_next = RING_LOAD;
            end else begin
              snz_cnt_next = snz_cnt_reg - SNZ_W'(1);
            end
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ring_cnt_reg <= '0;
      block_reg    <= 1'b0;
      alarm_reg    <= 1'b0;
      snoozed_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ring_cnt_reg <= ring_cnt_next;
      block_reg    <= block_next;
      alarm_reg    <= (state_next == RINGING);
      snoozed_reg  <= (state_next == SNOOZED);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_cnt_reg <= '0;
      scount_reg  <= '0;
    end else begin
      snz_cnt_reg <= snz_cnt_next;
      scount_reg  <= scount_next;
    end
  end

  assign snoozed      = snoozed_reg;
  assign snooze_count = scount_reg;
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ snoozed_reg;
  assign snoozed       = 1'b0;
  assign snooze_count  = 2'd0;
`endif

  assign alarm = alarm_reg;

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: stimulus queues expected outputs, a
// negedge monitor pops and compares them. Snooze tests follow ALARM_SNOOZE_EN.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [4:0] alm_hours;
  logic [5:0] alm_minutes;
  logic       alarm_en;
  logic       dismiss;
  logic       snooze;
  logic       alarm;
  logic       snoozed;
  logic [1:0] snooze_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       a;
    logic       s;
    logic [1:0] c;
  } exp_t;

  exp_t exp_q[$];

  alarm_trigger #(
    .RING_SECONDS  (5),
    .SNOOZE_SECONDS(3),
    .MAX_SNOOZES   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .cur_seconds (cur_seconds),
    .alm_hours   (alm_hours),
    .alm_minutes (alm_minutes),
    .alarm_en    (alarm_en),
    .dismiss     (dismiss),
    .snooze      (snooze),
    .alarm       (alarm),
    .snoozed     (snoozed),
    .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs at negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (alarm !== e.a || snoozed !== e.s || snooze_count !== e.c) begin
        errors++;
        $display("FAIL %s: got alarm=%b snoozed=%b count=%0d, want alarm=%b snoozed=%b count=%0d",
                 e.name, alarm, snoozed, snooze_count, e.a, e.s, e.c);
      end else begin
        $display("ok   %s: alarm=%b snoozed=%b count=%0d", e.name, alarm, snoozed, snooze_count);
      end
    end
  end

  task automatic expect_out(input string name, input logic a, input logic s, input logic [1:0] c);
    exp_t e;
    e.name = name;
    e.a    = a;
    e.s    = s;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ticks are spaced 10 clocks apart.
  task automatic do_tick();
    repeat (9) step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hours   = h;
    cur_minutes = m;
    cur_seconds = s;
  endtask

  // Leave the alarm minute (clears the block latch), then match at 07:30:00.
  task automatic fresh_ring(input string name, input logic [1:0] c);
    set_time(5'd7, 6'd31, 6'd0);
    step();
    set_time(5'd7, 6'd30, 6'd0);
    do_tick();
    expect_out(name, 1'b1, 1'b0, c);
    cur_seconds = 6'd1;
  endtask

  initial begin
    reset     = 1'b1;
    tick_1hz  = 1'b0;
    dismiss   = 1'b0;
    snooze    = 1'b0;
    alarm_en  = 1'b1;
    alm_hours = 5'd7;
    alm_minutes = 6'd30;
    set_time(5'd7, 6'd29, 6'd59);
    step();
    expect_out("reset_state", 1'b0, 1'b0, 2'd0);
    step();
    reset = 1'b0;
    step();

    // Match and timeout
    do_tick();
    expect_out("pre_match_quiet", 1'b0, 1'b0, 2'd0);
    set_time(5'd7, 6'd30, 6'd0);
    do_tick();
    expect_out("match_rise", 1'b1, 1'b0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      cur_seconds = 6'(i);
      do_tick();
      expect_out($sformatf("ring_tick%0d", i), 1'b1, 1'b0, 2'd0);
    end
    cur_seconds = 6'd5;
    do_tick();
    expect_out("ring_timeout", 1'b0, 1'b0, 2'd0);

    // Dismiss, no re-trigger in the same minute, latch clears at 07:31
    cur_seconds = 6'd0;
    do_tick();
    expect_out("rering_same_min", 1'b1, 1'b0, 2'd0);
    cur_seconds = 6'd1;
    repeat (3) step();
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    expect_out("dismiss_drop", 1'b0, 1'b0, 2'd0);
    cur_seconds = 6'd0;
    do_tick();
    expect_out("no_retrigger", 1'b0, 1'b0, 2'd0);
    fresh_ring("latch_cleared", 2'd0);

    // Dismiss and snooze together
    repeat (2) step();
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    dismiss = 1'b0;
    snooze  = 1'b0;
    expect_out("dismiss_over_snooze", 1'b0, 1'b0, 2'd0);

    // Match qualifiers
    alarm_en = 1'b0;
    set_time(5'd7, 6'd31, 6'd0);
    step();
    set_time(5'd7, 6'd30, 6'd0);
    do_tick();
    expect_out("en_low_no_match", 1'b0, 1'b0, 2'd0);
    alarm_en = 1'b1;
    repeat (12) step();
    expect_out("no_tick_no_match", 1'b0, 1'b0, 2'd0);
    set_time(5'd8, 6'd30, 6'd0);
    do_tick();
    expect_out("hour_mismatch", 1'b0, 1'b0, 2'd0);
    set_time(5'd7, 6'd30, 6'd5);
    do_tick();
    expect_out("sec_nonzero", 1'b0, 1'b0, 2'd0);

    // alarm_en dropped mid-ring
    cur_seconds = 6'd0;
    do_tick();
    expect_out("ring_for_disable", 1'b1, 1'b0, 2'd0);
    cur_seconds = 6'd1;
    repeat (2) step();
    alarm_en = 1'b0;
    step();
    expect_out("disable_drop", 1'b0, 1'b0, 2'd0);
    alarm_en = 1'b1;
    step();

`ifdef ALARM_SNOOZE_EN
    fresh_ring("snz_ring", 2'd0);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("snooze1", 1'b0, 1'b1, 2'd1);
    do_tick();
    expect_out("snz1_tick1", 1'b0, 1'b1, 2'd1);
    do_tick();
    expect_out("snz1_tick2", 1'b0, 1'b1, 2'd1);
    do_tick();
    expect_out("snz1_rering", 1'b1, 1'b0, 2'd1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("snooze2", 1'b0, 1'b1, 2'd2);
    do_tick();
    do_tick();
    expect_out("snz2_tick2", 1'b0, 1'b1, 2'd2);
    do_tick();
    expect_out("snz2_rering", 1'b1, 1'b0, 2'd2);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("snooze_limit", 1'b1, 1'b0, 2'd2);
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      expect_out($sformatf("limit_tick%0d", i), 1'b1, 1'b0, 2'd2);
    end
    do_tick();
    expect_out("limit_timeout", 1'b0, 1'b0, 2'd0);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("snooze_in_idle", 1'b0, 1'b0, 2'd0);

    // Reset while snoozed
    fresh_ring("ring_for_reset", 2'd0);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("snooze_before_reset", 1'b0, 1'b1, 2'd1);
    step();
`else
    fresh_ring("nosnz_ring", 2'd0);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("snooze_ignored", 1'b1, 1'b0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      expect_out($sformatf("nosnz_tick%0d", i), 1'b1, 1'b0, 2'd0);
    end
    do_tick();
    expect_out("nosnz_timeout", 1'b0, 1'b0, 2'd0);

    // Reset while ringing
    fresh_ring("ring_for_reset", 2'd0);
    step();
`endif
    // Asserted just after an edge; monitor samples before the next one.
    reset = 1'b1;
    expect_out("reset_async", 1'b0, 1'b0, 2'd0);
    step();
    reset = 1'b0;
    cur_seconds = 6'd1;
    do_tick();
    expect_out("post_reset_quiet", 1'b0, 1'b0, 2'd0);
    cur_seconds = 6'd0;
    do_tick();
    expect_out("post_reset_rematch", 1'b1, 1'b0, 2'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations still queued, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

Time-compare and ring-control stage directly upstream of `led_alarm`. Compares the running clock time against the user-set alarm time once per second and drives the `alarm` trigger that `led_alarm` consumes. Also handles dismiss, snooze with a bounded re-ring count, and an automatic ring timeout.

## Interface
Parameters:
- `RING_SECONDS`, 60: number of 1 Hz ticks the alarm rings before it stops on its own.
- `SNOOZE_SECONDS`, 300: number of 1 Hz ticks spent snoozed before ringing again.
- `MAX_SNOOZES`, 3: number of snoozes accepted per alarm event.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `tick_1hz` input 1: one-`clk`-cycle enable pulse, once per second.
- `cur_hours` input 5: current hours, binary, 0–23.
- `cur_minutes` input 6: current minutes, binary, 0–59.
- `cur_seconds` input 6: current seconds, binary, 0–59.
- `alm_hours` input 5: alarm hours, binary.
- `alm_minutes` input 6: alarm minutes, binary.
- `alarm_en` input 1: alarm armed (level).
- `dismiss` input 1: single-cycle pulse from the debounced button.
- `snooze` input 1: single-cycle pulse from the debounced button.
- `alarm` output 1: ring request to `led_alarm` (level).
- `snoozed` output 1: high while in SNOOZED.
- `snooze_count` output 2: snoozes used in the current event.

## Operation
States:
- IDLE: quiet.
- RINGING: `alarm` is high.
- SNOOZED: waiting to ring again.

Match condition:
- Evaluated only in a cycle where `tick_1hz` is high.
- Requires `alarm_en=1`, `cur_hours==alm_hours`, `cur_minutes==alm_minutes` and `cur_seconds==0`.

Transitions, in priority order each cycle:
1. `alarm_en=0`:
   - Any state goes to IDLE.
   - Counters and `snooze_count` clear.
2. `dismiss` in RINGING or SNOOZED:
   - Go to IDLE and clear `snooze_count`.
   - Set the match-block latch.
3. `snooze` in RINGING with `snooze_count < MAX_SNOOZES`:
   - Go to SNOOZED.
   - Load the snooze counter with `SNOOZE_SECONDS`.
   - Increment `snooze_count`.
4. `snooze` in RINGING with `snooze_count == MAX_SNOOZES`: ignored; ringing continues.
5. RINGING on a tick:
   - Decrement the ring counter.
   - When it reaches 0: go to IDLE and clear `snooze_count`.
6. SNOOZED on a tick:
   - Decrement the snooze counter.
   - When it reaches 0: go to RINGING and reload the ring counter with `RING_SECONDS`.
7. IDLE when the match condition holds and the match-block latch is clear:
   - Go to RINGING.
   - Load the ring counter with `RING_SECONDS`.

Other rules:
- The match-block latch clears when `cur_minutes != alm_minutes`. Dismissing within the alarm minute therefore never re-triggers, even if time is re-set to second 0.
- `snooze` in IDLE or SNOOZED is ignored. `dismiss` in IDLE is ignored.
- Counter widths are derived from their parameters via `$clog2` and sized to hold the parameter value.
- Changing `alm_*` while ringing does not affect the current event.

## Timing
- Reset values:
  - State is IDLE.
  - `alarm=0`, `snoozed=0`, `snooze_count=0`.
  - All counters are 0 and the match-block latch is clear.
- All outputs are registered and decoded from state.
- `alarm` rises on the first clock edge after the `tick_1hz` cycle that satisfies the match.
- `alarm` falls on the edge after a `dismiss` or `snooze` cycle, or after the timeout tick.
- The ring duration is exactly `RING_SECONDS` ticks, counted from the matching tick (exclusive) to the tick that ends it (inclusive).
- Button pulses act in the cycle they are high and are not queued. A pulse that coincides with `tick_1hz` takes priority over the counter update.
- Reset asserted mid-ring:
  - `alarm` drops asynchronously.
  - After release, the block re-rings only on a fresh match at second 0.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - Snooze logic is as described above.
- `ALARM_SNOOZE_EN` undefined:
  - `snooze` is ignored.
  - The SNOOZED state and snooze counter are not built.
  - `snoozed` is tied to 0 and `snooze_count` to 0.
  - Dismiss and timeout behave as above.

## Test plan
Benches use `RING_SECONDS=5`, `SNOOZE_SECONDS=3`, `MAX_SNOOZES=2`, with ticks spaced 10 clocks apart.
- Match timeout: alarm set to 07:30, time steps 07:29:59 → 07:30:00 → `alarm=1` one clock after the matching tick, `alarm=0` after 5 more ticks, `snooze_count=0`.
- Dismiss and no re-trigger: dismiss during ring → `alarm=0` next clock; time forced back to 07:30:00 in the same minute → `alarm` stays 0; at 07:31 the latch clears.
- Snooze cycle: snooze during ring → `snoozed=1`, `alarm=0`, `snooze_count=1`; after 3 ticks → `alarm=1` and rings again.
- Snooze limit: two snoozes accepted (`snooze_count=2`); a third snooze → ignored, `alarm` stays 1 until timeout.
- Priority and disable: `dismiss` and `snooze` in the same cycle → IDLE, `snooze_count=0`; `alarm_en` dropped mid-ring → `alarm=0` next clock; reset mid-snooze → all outputs 0 immediately.
- `ALARM_SNOOZE_EN` undefined: snooze pulse during ring → `alarm` stays 1, `snoozed=0`, timeout after 5 ticks.
